// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and field constants for the program sequencer
package seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_MEMW  = 2'd3
    } state_t;

    localparam int INST_W     = 13;
    localparam int OFF_HI_MSB = 5;
    localparam int OFF_HI_LSB = 4;
    localparam int OFF_LO_MSB = 1;
    localparam int OFF_LO_LSB = 0;

    // Branch offset is split across the IR: {IR[5:4], IR[1:0]}, two's complement.
    function automatic logic [3:0] ir_offset(input logic [INST_W-1:0] ir);
        return {ir[OFF_HI_MSB:OFF_HI_LSB], ir[OFF_LO_MSB:OFF_LO_LSB]};
    endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// rtl/program_sequencer_if.sv - instruction/data memory handshake and write strobes
interface program_sequencer_if #(
    parameter int PC_W = 8
);
    logic                       imem_req;
    logic [PC_W-1:0]            imem_addr;
    logic                       imem_ack;
    logic [seq_pkg::INST_W-1:0] imem_data;
    logic                       dmem_req;
    logic                       dmem_ack;
    logic                       reg_we;
    logic                       mem_we;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_data,
        output dmem_req,
        input  dmem_ack,
        output reg_we, mem_we
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_data,
        input  dmem_req,
        output dmem_ack,
        input  reg_we, mem_we
    );
endinterface

// File: rtl/pc_next_logic.sv
// rtl/pc_next_logic.sv - combinational next-PC selector (increment, branch, jump)
module pc_next_logic
    import seq_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic [PC_W-1:0] i_pc,
    input  logic [3:0]      i_off,
    input  logic            i_pl,
    input  logic            i_jb,
    input  logic            i_bc,
    input  logic            i_z,
    input  logic            i_n,
    input  logic [PC_W-1:0] i_jump_target,
    output logic [PC_W-1:0] o_pc_next
);
    logic [PC_W-1:0] w_off_ext;
    logic [PC_W-1:0] w_pc_inc;
    logic            w_taken;

    assign w_off_ext = {{(PC_W-4){i_off[3]}}, i_off};
    assign w_pc_inc  = i_pc + PC_W'(1);
    // bc selects which flag qualifies the conditional branch.
    assign w_taken   = i_bc ? i_n : i_z;

    always_comb begin
        o_pc_next = w_pc_inc;
        if (i_pl) begin
            if (i_jb)
                o_pc_next = i_jump_target;
            else if (w_taken)
                o_pc_next = i_pc + w_off_ext;
        end
    end
endmodule

// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - fetch/execute controller owning PC, IR and the commit cycle
module program_sequencer
    import seq_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic                step,
    program_sequencer_if.master bus,
    output logic [INST_W-1:0]   inst,
    input  logic                pl,
    input  logic                jb,
    input  logic                bc,
    input  logic                md,
    input  logic                mw,
    input  logic                rw,
    input  logic                z,
    input  logic                n,
    input  logic [PC_W-1:0]     jump_target,
    output logic [PC_W-1:0]     pc,
    output logic                busy,
    output logic [CNT_W-1:0]    retired
);
    state_t            r_state;
    logic [PC_W-1:0]   r_pc;
    logic [INST_W-1:0] r_ir;
    logic [CNT_W-1:0]  r_retired;
    logic              r_step;

    logic              w_mem_op;
    logic              w_commit;
    logic [PC_W-1:0]   w_pc_next;
    logic [3:0]        w_off;

    assign w_mem_op = md | mw;
    assign w_off    = ir_offset(r_ir);

    // Commit is qualified by rst_n so an ack landing in the reset cycle never writes.
    always_comb begin
        w_commit = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_EXEC:  w_commit = !w_mem_op || bus.dmem_ack;
                S_MEMW:  w_commit = bus.dmem_ack;
                default: w_commit = 1'b0;
            endcase
        end
    end

    pc_next_logic #(.PC_W(PC_W)) u_pc_next (
        .i_pc          (r_pc),
        .i_off         (w_off),
        .i_pl          (pl),
        .i_jb          (jb),
        .i_bc          (bc),
        .i_z           (z),
        .i_n           (n),
        .i_jump_target (jump_target),
        .o_pc_next     (w_pc_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_retired <= '0;
            r_step    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run || step) begin
                        r_step  <= step;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (bus.imem_ack) begin
                        r_ir    <= bus.imem_data;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (!w_commit)
                        r_state <= S_MEMW;
                end
                S_MEMW: ;
                default: r_state <= S_IDLE;
            endcase
            if (w_commit) begin
                r_pc      <= w_pc_next;
                r_retired <= r_retired + CNT_W'(1);
                r_step    <= 1'b0;
                r_state   <= (run && !r_step) ? S_FETCH : S_IDLE;
            end
        end
    end

    assign bus.imem_req  = rst_n && (r_state == S_FETCH);
    assign bus.imem_addr = r_pc;
    assign bus.dmem_req  = rst_n && (((r_state == S_EXEC) && w_mem_op) || (r_state == S_MEMW));
    assign bus.reg_we    = rw & w_commit;
    assign bus.mem_we    = mw & w_commit;

    assign inst    = r_ir;
    assign pc      = r_pc;
    assign busy    = (r_state != S_IDLE);
    assign retired = r_retired;
endmodule

// File: tb/tb_program_sequencer.sv
// tb/tb_program_sequencer.sv - scoreboard bench for program_sequencer
module tb_program_sequencer;
    import seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, run, step;
    logic [12:0] inst;
    logic        pl, jb, bc, md, mw, rw, z, n;
    logic [7:0]  jump_target, pc;
    logic        busy;
    logic [15:0] retired;

    program_sequencer_if #(.PC_W(8)) bus_if ();

    program_sequencer #(.PC_W(8), .RESET_PC(8'd0), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .step(step), .bus(bus_if.master),
        .inst(inst), .pl(pl), .jb(jb), .bc(bc), .md(md), .mw(mw), .rw(rw),
        .z(z), .n(n), .jump_target(jump_target), .pc(pc), .busy(busy), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  exp_pc;
        logic [15:0] exp_ret;
        int          exp_reg_we;
        int          exp_mem_we;
        int          exp_dreq;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [15:0] exp_ret = 0;
    logic mon_en = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // Monitor: a change in retired marks a completed instruction.
    initial begin : monitor
        logic [15:0] last_ret = 0;
        int c_reg = 0, c_mem = 0, c_dreq = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && retired !== last_ret) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_retire", 32'(retired), 32'(last_ret));
                end else begin
                    e = exp_q.pop_front();
                    chk("pc", 32'(pc), 32'(e.exp_pc));
                    chk("retired", 32'(retired), 32'(e.exp_ret));
                    chk("reg_we_pulses", c_reg, e.exp_reg_we);
                    chk("mem_we_pulses", c_mem, e.exp_mem_we);
                    chk("dmem_req_cycles", c_dreq, e.exp_dreq);
                end
            end
            if (!mon_en || retired !== last_ret) begin
                c_reg = 0; c_mem = 0; c_dreq = 0;
            end
            last_ret = retired;
            if (mon_en) begin
                c_reg  += int'(bus_if.reg_we);
                c_mem  += int'(bus_if.mem_we);
                c_dreq += int'(bus_if.dmem_req);
            end
        end
    end

    task automatic push(input logic [7:0] epc, input int rwe, input int mwe, input int dreq);
        exp_t e;
        exp_ret      = exp_ret + 16'd1;
        e.exp_pc     = epc;
        e.exp_ret    = exp_ret;
        e.exp_reg_we = rwe;
        e.exp_mem_we = mwe;
        e.exp_dreq   = dreq;
        exp_q.push_back(e);
    endtask

    // Drives one instruction from the FETCH state through commit; returns #1 after the commit edge.
    task automatic do_instr(input logic [12:0] d, input logic [7:0] ctl, input logic [7:0] jt,
                            input int fw, input int dw);
        int t = 0;
        while (!bus_if.imem_req && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 50) chk("fetch_timeout", 32'(t), 32'(0));
        repeat (fw) begin @(posedge clk); #1; end
        bus_if.imem_ack  = 1'b1;
        bus_if.imem_data = d;
        {pl, jb, bc, md, mw, rw, z, n} = ctl;
        jump_target = jt;
        @(posedge clk); #1;
        bus_if.imem_ack = 1'b0;
        if (md || mw) begin
            repeat (dw) begin @(posedge clk); #1; end
            bus_if.dmem_ack = 1'b1;
            @(posedge clk); #1;
            bus_if.dmem_ack = 1'b0;
        end else begin
            @(posedge clk); #1;
        end
    endtask

    // ctl bit order: pl jb bc md mw rw z n
    localparam logic [7:0] C_ALU  = 8'b0000_0100;
    localparam logic [7:0] C_JMP  = 8'b1100_0000;
    localparam logic [7:0] C_BZ1  = 8'b1000_0010;
    localparam logic [7:0] C_BZ0  = 8'b1000_0000;
    localparam logic [7:0] C_BN1  = 8'b1010_0001;
    localparam logic [7:0] C_NOP  = 8'b0000_0000;
    localparam logic [7:0] C_ST   = 8'b0000_1000;
    localparam logic [7:0] C_LD   = 8'b0001_0100;
    localparam logic [12:0] BR_M3 = 13'h0031;   // off {11,01} = -3

    initial begin
        rst_n = 1'b0; run = 1'b0; step = 1'b0;
        {pl, jb, bc, md, mw, rw, z, n} = '0;
        jump_target = '0;
        bus_if.imem_ack = 1'b0; bus_if.imem_data = '0; bus_if.dmem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_pc", 32'(pc), 32'(0));
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_imem_req", 32'(bus_if.imem_req), 32'(0));
        chk("reset_dmem_req", 32'(bus_if.dmem_req), 32'(0));
        chk("reset_retired", 32'(retired), 32'(0));
        chk("reset_inst", 32'(inst), 32'(0));

        run = 1'b1;
        @(posedge clk); #1;
        chk("first_req", 32'(bus_if.imem_req), 32'(1));
        chk("first_addr", 32'(bus_if.imem_addr), 32'(0));

        push(8'd1, 1, 0, 0);    do_instr(13'h0035, C_ALU, 8'h00, 0, 0);
        chk("refetch_req", 32'(bus_if.imem_req), 32'(1));
        chk("refetch_addr", 32'(bus_if.imem_addr), 32'(1));
        chk("ir_latched", 32'(inst), 32'(13'h0035));
        push(8'd10, 0, 0, 0);   do_instr(13'h1000, C_JMP, 8'd10, 1, 0);
        push(8'd7, 0, 0, 0);    do_instr(BR_M3, C_BZ1, 8'h00, 0, 0);
        push(8'd10, 0, 0, 0);   do_instr(13'h1000, C_JMP, 8'd10, 0, 0);
        push(8'd11, 0, 0, 0);   do_instr(BR_M3, C_BZ0, 8'h00, 0, 0);
        push(8'd2, 0, 0, 0);    do_instr(13'h1000, C_JMP, 8'd2, 0, 0);
        push(8'd255, 0, 0, 0);  do_instr(BR_M3, C_BN1, 8'h00, 0, 0);
        push(8'd0, 0, 0, 0);    do_instr(13'h0000, C_NOP, 8'h00, 2, 0);
        push(8'h42, 0, 0, 0);   do_instr(13'h1000, C_JMP, 8'h42, 0, 0);
        push(8'h43, 0, 1, 4);   do_instr(13'h0400, C_ST, 8'h00, 0, 3);
        run = 1'b0;
        push(8'h44, 1, 0, 1);   do_instr(13'h0200, C_LD, 8'h00, 0, 0);
        chk("idle_after_run_off", 32'(busy), 32'(0));
        @(posedge clk); #1;
        chk("idle_no_fetch", 32'(bus_if.imem_req), 32'(0));

        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        push(8'h45, 1, 0, 0);   do_instr(13'h0035, C_ALU, 8'h00, 0, 0);
        chk("step_returns_idle", 32'(busy), 32'(0));
        @(posedge clk); #1;
        chk("step_single_instr", 32'(bus_if.imem_req), 32'(0));

        // Reset during a memory wait with an ack arriving in the reset cycle.
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        bus_if.imem_ack = 1'b1; bus_if.imem_data = 13'h0400;
        {pl, jb, bc, md, mw, rw, z, n} = C_ST;
        @(posedge clk); #1;
        bus_if.imem_ack = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("memw_dmem_req", 32'(bus_if.dmem_req), 32'(1));
        mon_en = 1'b0;
        rst_n = 1'b0; bus_if.dmem_ack = 1'b1;
        #2;
        chk("rst_no_mem_we", 32'(bus_if.mem_we), 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1; bus_if.dmem_ack = 1'b0;
        chk("rst_memw_pc", 32'(pc), 32'(0));
        chk("rst_memw_busy", 32'(busy), 32'(0));
        chk("rst_memw_retired", 32'(retired), 32'(0));
        chk("rst_memw_dmem_req", 32'(bus_if.dmem_req), 32'(0));
        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Multi-cycle fetch/execute controller for the 13-bit single-bus computer.
- Owns the program counter (PC) and instruction register (IR).
- Drives the instruction memory handshake and presents IR to the instruction decoder.
- Consumes the decoder's PL/JB/BC/MD/MW/RW controls and the function-unit Z/N flags, then gates register and memory writes to a single commit cycle per instruction.

Parameters:
- PC_W, 8: program counter and instruction address width.
- RESET_PC, 0: PC value loaded on reset.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active low.
- run  in  1  level; while high, instructions execute back-to-back.
- step  in  1  one-cycle pulse; executes exactly one instruction when idle.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_W  fetch address; always equals pc.
- imem_ack  in  1  fetch data valid this cycle.
- imem_data  in  13  fetched instruction.
- inst  out  13  IR contents, feeds the decoder.
- pl, jb, bc, md, mw, rw  in  1 each  decoder control outputs for inst.
- z, n  in  1 each  function-unit zero/negative flags for the current instruction.
- jump_target  in  PC_W  A-bus value, used when PL=1 and JB=1.
- dmem_req  out  1  data memory access request.
- dmem_ack  in  1  data memory access complete.
- reg_we  out  1  register file write enable, equal to rw & commit.
- mem_we  out  1  data memory write enable, equal to mw & commit.
- pc  out  PC_W  current program counter.
- busy  out  1  high in every state except IDLE.
- retired  out  CNT_W  count of committed instructions.

Behaviour:
- Reset, synchronous on rst_n=0 at the clk edge:
  - state=IDLE, pc=RESET_PC, IR=0, retired=0.
  - imem_req, dmem_req, reg_we, mem_we and busy are all 0.
  - Reset overrides any state, including mid-fetch or mid-memwait. An ack arriving in the reset cycle is ignored.
- States: IDLE, FETCH, EXEC, MEMW.
- IDLE:
  - Moves to FETCH when run=1 or step=1.
  - Latches a step request; step pulses seen outside IDLE are ignored.
- FETCH:
  - imem_req=1 and imem_addr=pc, held stable until imem_ack.
  - On imem_ack: IR<=imem_data and next state is EXEC.
  - The minimum fetch is 1 cycle, with ack in the same cycle as req.
- EXEC:
  - If md|mw=0, this cycle is the commit cycle.
  - Otherwise dmem_req=1 and the state moves to MEMW, or commits in EXEC if dmem_ack=1 in the same cycle.
- MEMW:
  - dmem_req=1 is held until dmem_ack.
  - The cycle in which dmem_ack arrives is the commit cycle.
- At the commit cycle:
  - reg_we and mem_we pulse for exactly 1 cycle.
  - retired increments and wraps modulo 2^CNT_W.
  - pc is updated as follows, with all arithmetic modulo 2^PC_W and no overflow flag:
    - pl=1 and jb=1: pc<=jump_target.
    - pl=1, jb=0, bc=0: pc<=pc+sext(off) if z=1, else pc+1.
    - pl=1, jb=0, bc=1: pc<=pc+sext(off) if n=1, else pc+1.
    - pl=0: pc<=pc+1.
  - off is the 4-bit signed value {IR[5:4],IR[1:0]}, range -8..+7. It is sign-extended to PC_W.
  - Next state is FETCH if run=1 and no step was latched; otherwise IDLE, clearing the step latch.
- Latency: a non-memory instruction takes fetch latency + 1 cycle. A memory instruction adds the cycles spent in MEMW.
- Deasserting run takes effect only at an instruction boundary; an in-flight instruction always completes.
- pc=2^PC_W-1 with pl=0 wraps to 0.

Decomposition:
- Shared package seq_pkg:
  - state enum (IDLE/FETCH/EXEC/MEMW).
  - INST_W=13.
  - Field slice constants OFF_HI=[5:4] and OFF_LO=[1:0].
- One natural sub-module, pc_next_logic: a combinational next-PC selector taking pc, IR offset, pl/jb/bc, z/n and jump_target.
- The FSM, IR, counter and write gating stay in program_sequencer.

Test Plan:
- Reset with rst_n=0 for 2 cycles, RESET_PC=0 -> pc=0, busy=0, no req; run=1 -> imem_req=1, imem_addr=0 next cycle.
- run=1, zero-wait ALU instruction 13'h0035 (rw=1) -> reg_we pulses once 1 cycle after ack, pc=1, retired=1, then immediate re-fetch at addr 1.
- Branch on zero at pc=10 with off=4'b1101 (-3): z=1 -> pc=7; z=0 -> pc=11. Branch at pc=2 with off=-3 -> pc=255 (wrap).
- Jump with pl=jb=1 and jump_target=8'h42 -> pc=0x42; with pc=255 and pl=0 -> pc=0.
- Store with mw=1 and dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, mem_we pulses only in the ack cycle, reg_we=0, pc+1 at that cycle.
- run=0 with a single step pulse -> exactly one instruction executes, retired+1, return to IDLE. rst_n=0 asserted during MEMW -> IDLE, pc=RESET_PC, no write pulse.
